// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: the NOP encoding,
// the queue entry layout and the byte-address to word-index mapping.
package if_pkg;

   localparam int FETCH_XLEN = 32;

   localparam logic [FETCH_XLEN-1:0] INSN_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] ins;
      logic [FETCH_XLEN-1:0] pc;
   } fetch_entry_t;

   // Byte address to IMEM word index; words must be a power of two so the
   // mask gives the modulo wrap.
   function automatic int unsigned word_idx(input logic [63:0] addr,
                                            input int unsigned words);
      return 32'(addr >> 2) & (words - 1);
   endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Decode-side and control-side signal bundle of the fetch stage.
interface if_fetch_queue_if #(
   parameter int XLEN   = 32,
   parameter int QDEPTH = 4
);
   localparam int CW = $clog2(QDEPTH) + 1;

   logic            we;
   logic [XLEN-1:0] waddr;
   logic [XLEN-1:0] wdata;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   // out_valid/out_ready: the head transfers on a rising edge where both are
   // 1; out_valid never depends on out_ready, and once raised the head holds
   // until it transfers or a redirect/reset discards it.
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_ins;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_npc;
   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   q_count;

   modport master (
      input  we, waddr, wdata, redirect, redirect_pc, out_ready,
      output out_valid, out_ins, out_pc, out_npc, fetch_pc, q_count
   );

   modport slave (
      output we, waddr, wdata, redirect, redirect_pc, out_ready,
      input  out_valid, out_ins, out_pc, out_npc, fetch_pc, q_count
   );

endinterface

// File: rtl/if_queue.sv
// Synchronous circular-buffer FIFO with flush; head is read combinationally.
module if_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);
   localparam int AW  = $clog2(DEPTH);
   localparam int CW1 = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      cnt;

   always_ff @(posedge CLK) begin
      if (!RST || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW1'(push) - CW1'(pop);
      end
   end

   // Storage needs no reset; only entries below count are ever observed.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign count = cnt;
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC, synchronous-read IMEM with load port, and a
// prefetch queue feeding decode, with redirect flushing in-flight work.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter int              IMEM_WORDS = 256,
   parameter int              QDEPTH     = 4,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input logic               CLK,
   input logic               RST,
   if_fetch_queue_if.master  fq
);
   localparam int IW  = $clog2(IMEM_WORDS);
   localparam int QW  = $clog2(QDEPTH) + 1;
   localparam int QW1 = QW + 1;

   logic [XLEN-1:0]   imem [IMEM_WORDS];
   logic [XLEN-1:0]   fetch_pc_q;
   logic [XLEN-1:0]   issue_pc_q;
   logic [XLEN-1:0]   rd_data_q;
   logic              inflight_q;
   logic [QW-1:0]     q_count;
   logic [2*XLEN-1:0] head;
   logic [QW:0]       occupancy;
   logic [IW-1:0]     widx;
   logic [IW-1:0]     ridx;
   logic              pop;
   logic              issue;
   logic              push;

   assign pop  = fq.out_valid && fq.out_ready;
   assign widx = IW'(word_idx(64'(fq.waddr), int'(IMEM_WORDS)));
   assign ridx = IW'(word_idx(64'(fetch_pc_q), int'(IMEM_WORDS)));

   // Counting the in-flight word as occupied means its response always finds
   // a free slot, so the queue can never be pushed while full.
   assign occupancy = {1'b0, q_count} + QW1'(inflight_q) - QW1'(pop);
   assign issue     = RST && !fq.we && !fq.redirect && (occupancy < QW1'(QDEPTH));
   assign push      = RST && !fq.redirect && inflight_q;

   always_ff @(posedge CLK) begin
      if (RST && fq.we) imem[widx] <= fq.wdata;
   end

   always_ff @(posedge CLK) begin
      if (issue) rd_data_q <= imem[ridx];
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         fetch_pc_q <= RESET_PC;
         issue_pc_q <= '0;
         inflight_q <= 1'b0;
      end else if (fq.redirect) begin
         fetch_pc_q <= fq.redirect_pc & ~XLEN'(3);
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            issue_pc_q <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + XLEN'(4);
         end
      end
   end

   if_queue #(
      .WIDTH (2 * XLEN),
      .DEPTH (QDEPTH)
   ) u_queue (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .pop   (pop),
      .flush (fq.redirect),
      .din   ({rd_data_q, issue_pc_q}),
      .count (q_count),
      .head  (head)
   );

   assign fq.out_valid = (q_count != '0);
   assign fq.out_ins   = fq.out_valid ? head[2*XLEN-1:XLEN] : XLEN'(INSN_NOP);
   assign fq.out_pc    = head[XLEN-1:0];
   assign fq.out_npc   = head[XLEN-1:0] + XLEN'(4);
   assign fq.fetch_pc  = fetch_pc_q;
   assign fq.q_count   = q_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a main instance with reset vector 0 and a
// second instance whose reset vector sits on the last IMEM word.
module tb_if_fetch_queue;
   import if_pkg::*;

   localparam int          XLEN       = 32;
   localparam int          IMEM_WORDS = 32;
   localparam int          QDEPTH     = 4;
   localparam logic [31:0] WRAP_PC    = 32'((IMEM_WORDS - 1) * 4);

   logic CLK  = 1'b0;
   logic RST  = 1'b0;
   logic RST1 = 1'b0;

   always #5 CLK = ~CLK;

   if_fetch_queue_if #(.XLEN(XLEN), .QDEPTH(QDEPTH)) bus ();
   if_fetch_queue_if #(.XLEN(XLEN), .QDEPTH(QDEPTH)) bus1 ();

   if_fetch_queue #(
      .XLEN(XLEN), .IMEM_WORDS(IMEM_WORDS), .QDEPTH(QDEPTH), .RESET_PC(32'h0)
   ) dut (
      .CLK(CLK), .RST(RST), .fq(bus)
   );

   if_fetch_queue #(
      .XLEN(XLEN), .IMEM_WORDS(IMEM_WORDS), .QDEPTH(QDEPTH), .RESET_PC(WRAP_PC)
   ) dut_wrap (
      .CLK(CLK), .RST(RST1), .fq(bus1)
   );

   int           checks   = 0;
   int           failures = 0;
   fetch_entry_t exp_q[$];
   logic [31:0]  imem_m [IMEM_WORDS];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue the instruction expected for a fetch of pc, using the bench's IMEM image.
   task automatic expect_pc(input logic [31:0] pc);
      fetch_entry_t e;
      e.ins = imem_m[pc[6:2]];
      e.pc  = pc;
      exp_q.push_back(e);
   endtask

   // Score any transfer that will happen at the coming edge, then advance.
   task automatic tick();
      fetch_entry_t e;
      if (RST && !bus.redirect && bus.out_valid && bus.out_ready) begin
         chk("pop_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_ins", 64'(bus.out_ins), 64'(e.ins));
            chk("out_pc",  64'(bus.out_pc),  64'(e.pc));
            chk("out_npc", 64'(bus.out_npc), 64'(e.pc + 32'd4));
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input int idx, input logic [31:0] val);
      bus.we    = 1'b1;
      bus.waddr = 32'(idx * 4) | 32'($urandom_range(0, 3));
      bus.wdata = val;
      imem_m[idx] = val;
      tick();
      bus.we = 1'b0;
   endtask

   initial begin
      bus.we = 1'b0;  bus.waddr = '0;  bus.wdata = '0;
      bus.redirect = 1'b0;  bus.redirect_pc = '0;  bus.out_ready = 1'b0;
      bus1.we = 1'b0; bus1.waddr = '0; bus1.wdata = '0;
      bus1.redirect = 1'b0; bus1.redirect_pc = '0; bus1.out_ready = 1'b0;

      // Reset state
      repeat (2) tick();
      chk("rst_q_count",   64'(bus.q_count),   64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_fetch_pc",  64'(bus.fetch_pc),  64'd0);

      // Program load: writes suppress issue, so the PC stays at the vector
      RST = 1'b1;
      for (int i = 0; i < IMEM_WORDS; i++)
         load(i, (i < 4) ? 32'((i + 1) * 11) : 32'h1000 + 32'(i * 3));
      chk("load_fetch_pc", 64'(bus.fetch_pc), 64'd0);
      chk("load_q_count",  64'(bus.q_count),  64'd0);

      // Streaming with out_ready held: two-edge latency, then one per cycle
      for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
      bus.out_ready = 1'b1;
      tick();
      chk("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("lat_edge2_valid", 64'(bus.out_valid), 64'd1);
      chk("lat_edge2_pc",    64'(bus.out_pc),    64'd0);
      repeat (4) tick();
      bus.out_ready = 1'b0;
      chk("stream_all_seen", 64'(exp_q.size()), 64'd0);

      // Back-pressure: queue saturates, no push past full, PC stops
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("count_le_depth", 64'(bus.q_count <= 3'(QDEPTH)), 64'd1);
      end
      chk("full_q_count",  64'(bus.q_count),  64'd4);
      chk("full_fetch_pc", 64'(bus.fetch_pc), 64'd32);
      chk("full_head_pc",  64'(bus.out_pc),   64'd16);
      repeat (2) tick();
      chk("full_hold_pc",  64'(bus.fetch_pc), 64'd32);
      chk("full_hold_cnt", 64'(bus.q_count),  64'd4);

      // One pop leaves 3 queued with a fetch in flight
      expect_pc(32'd16);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("pop1_q_count",  64'(bus.q_count),    64'd3);
      chk("pop1_fetch_pc", 64'(bus.fetch_pc),   64'd36);
      chk("pop1_seen",     64'(exp_q.size()),   64'd0);

      // Redirect to an unaligned target flushes queue and in-flight word
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h41;
      tick();
      bus.redirect = 1'b0;
      chk("redir_q_count",   64'(bus.q_count),   64'd0);
      chk("redir_out_valid", 64'(bus.out_valid), 64'd0);
      chk("redir_fetch_pc",  64'(bus.fetch_pc),  64'h40);
      expect_pc(32'h40); expect_pc(32'h44); expect_pc(32'h48);
      bus.out_ready = 1'b1;
      tick();
      chk("redir_lat1_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("redir_first_pc",   64'(bus.out_pc),    64'h40);
      repeat (3) tick();
      chk("redir_all_seen",   64'(exp_q.size()),  64'd0);

      // Redirect with a simultaneous pop: head is discarded, not re-presented
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h8;
      tick();
      bus.redirect = 1'b0;
      chk("rpop_q_count",   64'(bus.q_count),   64'd0);
      chk("rpop_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rpop_fetch_pc",  64'(bus.fetch_pc),  64'h8);
      expect_pc(32'h8); expect_pc(32'hC);
      tick();
      chk("rpop_lat1_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("rpop_first_pc",   64'(bus.out_pc),    64'h8);
      repeat (2) tick();
      bus.out_ready = 1'b0;
      chk("rpop_all_seen",   64'(exp_q.size()),  64'd0);

      // Writes while streaming: in-flight word keeps old data, issue stalls
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0;
      tick();
      bus.redirect = 1'b0;
      expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
      bus.out_ready = 1'b1;
      repeat (3) tick();
      bus.we = 1'b1; bus.waddr = 32'h8; bus.wdata = 32'h0000_BEEF;
      imem_m[2] = 32'h0000_BEEF;
      tick();
      chk("wr_stall_pc1", 64'(bus.fetch_pc), 64'hC);
      bus.waddr = 32'h14; bus.wdata = 32'h0000_DEAD;
      imem_m[5] = 32'h0000_DEAD;
      tick();
      chk("wr_stall_pc2", 64'(bus.fetch_pc), 64'hC);
      bus.we = 1'b0;
      expect_pc(32'hC); expect_pc(32'h10); expect_pc(32'h14);
      tick();
      chk("wr_resume_pc", 64'(bus.fetch_pc), 64'h10);
      repeat (4) tick();
      bus.out_ready = 1'b0;
      chk("wr_all_seen",  64'(exp_q.size()), 64'd0);

      // Reset mid-stream; a write presented during reset is dropped
      RST = 1'b0;
      bus.we = 1'b1; bus.waddr = 32'hC; bus.wdata = 32'h77;
      tick();
      chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mrst_q_count",   64'(bus.q_count),   64'd0);
      chk("mrst_fetch_pc",  64'(bus.fetch_pc),  64'd0);
      RST = 1'b1;
      bus.we = 1'b0;
      for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
      bus.out_ready = 1'b1;
      repeat (2) tick();
      chk("mrst_valid_again", 64'(bus.out_valid), 64'd1);
      repeat (4) tick();
      bus.out_ready = 1'b0;
      chk("mrst_all_seen",    64'(exp_q.size()),  64'd0);

      // Reset vector on the last word: second fetch wraps to IMEM[0]
      chk("wrap_rst_pc",    64'(bus1.fetch_pc),  64'(WRAP_PC));
      chk("wrap_rst_valid", 64'(bus1.out_valid), 64'd0);
      RST1 = 1'b1;
      bus1.we = 1'b1; bus1.waddr = WRAP_PC; bus1.wdata = 32'hAA31;
      tick();
      bus1.waddr = 32'h0; bus1.wdata = 32'hBB00;
      tick();
      bus1.we = 1'b0;
      bus1.out_ready = 1'b1;
      tick();
      chk("wrap_fetch_pc", 64'(bus1.fetch_pc), 64'(WRAP_PC + 32'd4));
      tick();
      chk("wrap_v1",   64'(bus1.out_valid), 64'd1);
      chk("wrap_ins1", 64'(bus1.out_ins),   64'hAA31);
      chk("wrap_pc1",  64'(bus1.out_pc),    64'(WRAP_PC));
      chk("wrap_npc1", 64'(bus1.out_npc),   64'(WRAP_PC + 32'd4));
      tick();
      chk("wrap_ins2", 64'(bus1.out_ins),   64'hBB00);
      chk("wrap_pc2",  64'(bus1.out_pc),    64'(IMEM_WORDS * 4));
      chk("wrap_npc2", 64'(bus1.out_npc),   64'(IMEM_WORDS * 4 + 4));
      RST1 = 1'b0;
      tick();
      chk("wrap_mrst_valid", 64'(bus1.out_valid), 64'd0);
      chk("wrap_mrst_pc",    64'(bus1.fetch_pc),  64'(WRAP_PC));
      chk("wrap_mrst_count", 64'(bus1.q_count),   64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
